// File: rtl/fetch_pc_controller.sv
// Fetch-PC sequencer: owns the fetch PC and drives the dual-instruction memory handshake.
// Fetched pairs are buffered with their prediction until decode pops them.
module fetch_pc_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4,
    parameter int          CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_read,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_inst1,
    input  logic [31:0]      imem_inst2,
    input  logic             pred_take1,
    input  logic             pred_take2,
    input  logic [31:0]      pred_pc,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             deq_ready,
    output logic             deq_valid,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_inst1,
    output logic [31:0]      deq_inst2,
    output logic             deq_inst2_valid,
    output logic             deq_pred_taken,
    output logic [31:0]      deq_pred_pc,
    output logic [CNT_W-1:0] fq_count
);
    localparam int PTR_W = $clog2(FQ_DEPTH);

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        fq_pc_q    [FQ_DEPTH];
    logic [31:0]        fq_inst1_q [FQ_DEPTH];
    logic [31:0]        fq_inst2_q [FQ_DEPTH];
    logic [31:0]        fq_ppc_q   [FQ_DEPTH];
    logic               fq_v2_q    [FQ_DEPTH];
    logic               fq_tk_q    [FQ_DEPTH];

    logic               transfer_s, push_s, pop_s, taken_s;

    assign imem_read  = (state_q == RUN) && (cnt_q < CNT_W'(FQ_DEPTH));
    assign imem_addr  = pc_q;
    assign fq_count   = cnt_q;
    assign deq_valid  = (cnt_q != {CNT_W{1'b0}});
    assign transfer_s = imem_read && imem_ready;
    assign taken_s    = pred_take1 || pred_take2;
    assign push_s     = transfer_s && !redirect;
    assign pop_s      = deq_valid && deq_ready && !redirect;

    // Head data is zeroed while empty so stale entries never leak out.
    always_comb begin
        if (deq_valid) begin
            deq_pc          = fq_pc_q[rd_ptr_q];
            deq_inst1       = fq_inst1_q[rd_ptr_q];
            deq_inst2       = fq_inst2_q[rd_ptr_q];
            deq_inst2_valid = fq_v2_q[rd_ptr_q];
            deq_pred_taken  = fq_tk_q[rd_ptr_q];
            deq_pred_pc     = fq_ppc_q[rd_ptr_q];
        end else begin
            deq_pc          = 32'h0000_0000;
            deq_inst1       = 32'h0000_0000;
            deq_inst2       = 32'h0000_0000;
            deq_inst2_valid = 1'b0;
            deq_pred_taken  = 1'b0;
            deq_pred_pc     = 32'h0000_0000;
        end
    end

    // Next-state logic: redirect overrides any same-cycle transfer or pop.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (redirect) begin
            state_d  = BUBBLE;
            pc_d     = redirect_pc;
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                HOLD:    state_d = RUN;
                RUN:     state_d = RUN;
                BUBBLE:  state_d = RUN;
                default: state_d = HOLD;
            endcase
            if (transfer_s) begin
                pc_d = taken_s ? pred_pc : (pc_q + 32'd8);
            end else begin
                pc_d = pc_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HOLD;
            pc_q     <= RESET_PC;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Queue storage; contents are only observable through the gated head.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fq_pc_q[wr_ptr_q]    <= pc_q;
            fq_inst1_q[wr_ptr_q] <= imem_inst1;
            fq_inst2_q[wr_ptr_q] <= imem_inst2;
            fq_v2_q[wr_ptr_q]    <= !pred_take1;
            fq_tk_q[wr_ptr_q]    <= taken_s;
            fq_ppc_q[wr_ptr_q]   <= pred_pc;
        end
    end
endmodule

// File: tb/tb_fetch_pc_controller.sv
// Randomized bench for fetch_pc_controller: a queue-based reference model predicts
// the fetch stream while a negedge monitor compares the DUT against it.
module tb_fetch_pc_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_inst1, imem_inst2;
    logic        pred_take1, pred_take2;
    logic [31:0] pred_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc, deq_inst1, deq_inst2, deq_pred_pc;
    logic        deq_inst2_valid, deq_pred_taken;
    logic [2:0]  fq_count;

    fetch_pc_controller #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_inst1(imem_inst1), .imem_inst2(imem_inst2),
        .pred_take1(pred_take1), .pred_take2(pred_take2), .pred_pc(pred_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_pc(deq_pc),
        .deq_inst1(deq_inst1), .deq_inst2(deq_inst2),
        .deq_inst2_valid(deq_inst2_valid), .deq_pred_taken(deq_pred_taken),
        .deq_pred_pc(deq_pred_pc), .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, i1, i2, ppc;
        logic        v2, tk;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] m_pc  = 32'h0000_0000;
    bit          m_run = 1'b0;
    bit          m_read = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the queue is a plain list of pairs, the PC a number.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            m_pc  = 32'h0000_0000;
            m_run = 1'b0;
        end else if (redirect) begin
            sb.delete();
            m_pc  = redirect_pc;
            m_run = 1'b0;
        end else begin
            if (m_read && imem_ready) begin
                sb.push_back('{pc: m_pc, i1: imem_inst1, i2: imem_inst2, ppc: pred_pc,
                               v2: !pred_take1, tk: pred_take1 | pred_take2});
                m_pc = (pred_take1 | pred_take2) ? pred_pc : m_pc + 32'd8;
            end
            m_run = 1'b1;
        end
    end

    // Monitor: compares every cycle and retires the head pair when decode takes it.
    always @(negedge clk) begin
        m_read = m_run && (sb.size() < 4);
        chk("imem_read", {31'd0, imem_read}, {31'd0, m_read});
        chk("imem_addr", imem_addr, m_pc);
        chk("fq_count", {29'd0, fq_count}, sb.size());
        chk("deq_valid", {31'd0, deq_valid}, {31'd0, sb.size() != 0});
        if (sb.size() != 0) begin
            chk("deq_pc", deq_pc, sb[0].pc);
            chk("deq_inst1", deq_inst1, sb[0].i1);
            chk("deq_inst2", deq_inst2, sb[0].i2);
            chk("deq_inst2_valid", {31'd0, deq_inst2_valid}, {31'd0, sb[0].v2});
            chk("deq_pred_taken", {31'd0, deq_pred_taken}, {31'd0, sb[0].tk});
            chk("deq_pred_pc", deq_pred_pc, sb[0].ppc);
            if (deq_ready && !redirect && !rst) void'(sb.pop_front());
        end else begin
            chk("empty_deq_pc", deq_pc, 32'h0);
            chk("empty_deq_inst", deq_inst1 | deq_inst2 | deq_pred_pc, 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        imem_inst1 = $urandom;
        imem_inst2 = $urandom;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_inst1 = 32'h0; imem_inst2 = 32'h0;
        pred_take1 = 1'b0; pred_take2 = 1'b0; pred_pc = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; deq_ready = 1'b0;
        step(); step();
        chk("rst_read", {31'd0, imem_read}, 32'd0);
        chk("rst_count", {29'd0, fq_count}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // Fill: HOLD bubble, then pairs at 0x0, 0x8, 0x10, 0x18 until full.
        rst = 1'b0; imem_ready = 1'b1;
        chk("hold_read", {31'd0, imem_read}, 32'd0);
        repeat (5) step();
        chk("full_count", {29'd0, fq_count}, 32'd4);
        chk("full_addr", imem_addr, 32'h20);
        chk("full_read", {31'd0, imem_read}, 32'd0);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        chk("pop_count", {29'd0, fq_count}, 32'd3);
        chk("resume_read", {31'd0, imem_read}, 32'd1);
        step();
        chk("refill_count", {29'd0, fq_count}, 32'd4);
        chk("refill_addr", imem_addr, 32'h28);

        // Drain, then slot-1 and slot-2 taken predictions.
        imem_ready = 1'b0; deq_ready = 1'b1;
        repeat (4) step();
        deq_ready = 1'b0; imem_ready = 1'b1;
        pred_take1 = 1'b1; pred_pc = 32'h100;
        step();
        chk("take1_addr", imem_addr, 32'h100);
        chk("take1_v2", {31'd0, deq_inst2_valid}, 32'd0);
        pred_take1 = 1'b0; pred_take2 = 1'b1; pred_pc = 32'h200;
        step();
        chk("take2_addr", imem_addr, 32'h200);
        pred_take2 = 1'b0; pred_pc = 32'h0;
        step();
        chk("three_count", {29'd0, fq_count}, 32'd3);

        // Redirect collides with a transfer: flush, bubble, fetch at 0x80.
        redirect = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        chk("redir_count", {29'd0, fq_count}, 32'd0);
        chk("redir_valid", {31'd0, deq_valid}, 32'd0);
        chk("bubble_read", {31'd0, imem_read}, 32'd0);
        step();
        chk("post_bubble_read", {31'd0, imem_read}, 32'd1);
        chk("post_bubble_addr", imem_addr, 32'h80);
        step();
        chk("after_80_addr", imem_addr, 32'h88);

        // Memory stall, then reset mid-stall.
        imem_ready = 1'b0;
        repeat (5) step();
        chk("stall_addr", imem_addr, 32'h88);
        chk("stall_count", {29'd0, fq_count}, 32'd1);
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h444;
        step();
        rst = 1'b0; redirect = 1'b0;
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_count", {29'd0, fq_count}, 32'd0);
        chk("midrst_read", {31'd0, imem_read}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            imem_ready  = ($urandom_range(0, 9) < 7);
            pred_take1  = ($urandom_range(0, 9) == 0);
            pred_take2  = ($urandom_range(0, 9) == 0);
            pred_pc     = $urandom;
            deq_ready   = $urandom_range(0, 1);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom;
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; redirect = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
